// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default byte width and a constant-safe ceil(log2) helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;

  // ceil(log2(value)); usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns the first asserted request
// found scanning upward from rr_ptr, wrapping past NUM_REQ-1 back to 0.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] slot;

  // Scan offsets from farthest to nearest so the nearest hit to rr_ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      slot = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[slot]) begin
        valid = 1'b1;
        idx   = slot;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ clients.
// A granted byte is presented on TX_Data with transmit held high until the
// (slower) transmitter answers with busy; the client is then acked and the
// arbiter waits for busy to fall before granting again. A transmitter that
// never answers within START_TIMEOUT cycles raises timeout_err.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          TX_Data,
  output logic                       transmit,
  input  logic                       busy,
  output logic [clog2(NUM_REQ)-1:0]  active_id,
  output logic                       timeout_err,
  output logic                       idle
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = (clog2(START_TIMEOUT) < 1) ? 1 : clog2(START_TIMEOUT);

  state_t              state, state_next;
  logic                busy_meta, busy_s;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_next, active_id_next, pick_idx, ptr_after;
  logic                pick_valid;
  logic [DATA_W-1:0]   tx_data_next;
  logic                transmit_next, timeout_next;
  logic [NUM_REQ-1:0]  ack_next;
  logic [CNT_W-1:0]    cnt, cnt_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // busy synchronizer; left unreset so a frame still running through reset
  // is seen as busy immediately after reset releases.
  always_ff @(posedge clk) begin
    busy_meta <= busy;
    busy_s    <= busy_meta;
  end

  assign ptr_after = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + ID_W'(1);
  assign idle      = (state == IDLE);

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      active_id   <= '0;
      TX_Data     <= '0;
      transmit    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      active_id   <= active_id_next;
      TX_Data     <= tx_data_next;
      transmit    <= transmit_next;
      ack         <= ack_next;
      timeout_err <= timeout_next;
      cnt         <= cnt_next;
    end
  end

  // Next-state and next-output logic; pulses and transmit default low.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    active_id_next = active_id;
    tx_data_next   = TX_Data;
    transmit_next  = 1'b0;
    ack_next       = '0;
    timeout_next   = 1'b0;
    cnt_next       = '0;
    case (state)
      IDLE: begin
        if (pick_valid && !busy_s) begin
          active_id_next = pick_idx;
          tx_data_next   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          state_next     = LAUNCH;
        end
      end
      LAUNCH: begin
        if (busy_s) begin
          ack_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << active_id;
          rr_ptr_next = ptr_after;
          state_next  = WAIT_DONE;
        end else if (transmit && (cnt == CNT_W'(START_TIMEOUT - 1))) begin
          // Transmitter never answered: drop this client's turn without ack.
          timeout_next = 1'b1;
          rr_ptr_next  = ptr_after;
          state_next   = IDLE;
        end else begin
          transmit_next = 1'b1;
          // Count only cycles where transmit is actually presented.
          cnt_next      = transmit ? cnt + CNT_W'(1) : cnt;
        end
      end
      WAIT_DONE: begin
        if (!busy_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
